// File: rtl/gp_regfile.sv
// gp_regfile: general-purpose register file with a per-register busy scoreboard.
//
// Ports:
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   rsv_valid, rsv_addr     request to mark a register busy
//   rsv_ready               reservation accepted this cycle (combinational)
//   wr_enable, wr_addr,
//   wr_data                 write request (one per cycle)
//   wr_done                 registered one-cycle commit pulse
//   wr_err                  sticky: a write hit a register that was not busy
//   rd_a_addr/rd_a_data,
//   rd_b_addr/rd_b_data     two independent asynchronous read ports
//   busy                    per-register scoreboard bits
//
// Parameters: DATA_W, NUM_REGS (power of two), ADDR_W, HARDWIRE_R0 (register 0
// reads as zero, ignores writes and never becomes busy).
//
// Optional feature: define GP_REGFILE_BYPASS_EN to make a read port whose
// address matches an active write return wr_data in the same cycle.
module gp_regfile #(
  parameter int DATA_W      = 16,
  parameter int NUM_REGS    = 4,
  parameter int ADDR_W      = $clog2(NUM_REGS),
  parameter int HARDWIRE_R0 = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic                rsv_ready,
  input  logic                wr_enable,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_done,
  output logic                wr_err,
  input  logic [ADDR_W-1:0]   rd_a_addr,
  input  logic [ADDR_W-1:0]   rd_b_addr,
  output logic [DATA_W-1:0]   rd_a_data,
  output logic [DATA_W-1:0]   rd_b_data,
  output logic [NUM_REGS-1:0] busy
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_next;
  logic                wr_r0_hw;
  logic                rsv_busy;

  // A write to hardwired register 0 is acknowledged but has no other effect.
  assign wr_r0_hw = (HARDWIRE_R0 != 0) && (wr_addr == '0);

  // A write landing on the reserved register this cycle frees it, so the
  // reservation may be accepted even if the register is currently busy.
  assign rsv_busy  = busy_q[rsv_addr] && !(wr_enable && (wr_addr == rsv_addr));
  assign rsv_ready = rsv_valid && !rsv_busy;

  // Write clears first, reservation sets afterwards: reserve wins on a tie.
  always_comb begin
    busy_next = busy_q;
    if (wr_enable) busy_next[wr_addr] = 1'b0;
    if (rsv_ready) busy_next[rsv_addr] = 1'b1;
    if (HARDWIRE_R0 != 0) busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs    <= '{default: '0};
      busy_q  <= '0;
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      busy_q  <= busy_next;
      wr_done <= wr_enable;
      if (wr_enable && !wr_r0_hw) begin
        regs[wr_addr] <= wr_data;
        if (!busy_q[wr_addr]) wr_err <= 1'b1;
      end
    end
  end

  assign busy = busy_q;

  always_comb begin
    rd_a_data = regs[rd_a_addr];
`ifdef GP_REGFILE_BYPASS_EN
    if (wr_enable && !reset && (wr_addr == rd_a_addr)) rd_a_data = wr_data;
`endif
    if ((HARDWIRE_R0 != 0) && (rd_a_addr == '0)) rd_a_data = '0;
  end

  always_comb begin
    rd_b_data = regs[rd_b_addr];
`ifdef GP_REGFILE_BYPASS_EN
    if (wr_enable && !reset && (wr_addr == rd_b_addr)) rd_b_data = wr_data;
`endif
    if ((HARDWIRE_R0 != 0) && (rd_b_addr == '0)) rd_b_data = '0;
  end

endmodule

// File: tb/tb_gp_regfile.sv
// Bench for gp_regfile: two instances (HARDWIRE_R0=0 and =1) share one
// stimulus stream and are checked every cycle against an array-based model,
// plus literal expectations for the directed scenarios.
module tb_gp_regfile;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rsv_valid = 1'b0;
  logic [1:0]  rsv_addr = '0;
  logic        wr_enable = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  rd_a_addr = '0;
  logic [1:0]  rd_b_addr = '0;

  logic        rdy0, rdy1, done0, done1, err0, err1;
  logic [15:0] rda0, rdb0, rda1, rdb1;
  logic [3:0]  busy0, busy1;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  gp_regfile #(.DATA_W(16), .NUM_REGS(4), .HARDWIRE_R0(0)) u0 (
    .clk(clk), .reset(reset), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rsv_ready(rdy0), .wr_enable(wr_enable), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_done(done0), .wr_err(err0),
    .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
    .rd_a_data(rda0), .rd_b_data(rdb0), .busy(busy0));

  gp_regfile #(.DATA_W(16), .NUM_REGS(4), .HARDWIRE_R0(1)) u1 (
    .clk(clk), .reset(reset), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rsv_ready(rdy1), .wr_enable(wr_enable), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_done(done1), .wr_err(err1),
    .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
    .rd_a_data(rda1), .rd_b_data(rdb1), .busy(busy1));

  // ---------------- behavioural model ----------------
  logic [15:0] m_reg  [2][4];
  logic [3:0]  m_busy [2];
  logic        m_done [2];
  logic        m_err  [2];

  function automatic logic hw_zero(int k, logic [1:0] a);
    return (k == 1) && (a == 2'd0);
  endfunction

  function automatic logic [15:0] exp_rd(int k, logic [1:0] a);
    if (reset) return 16'h0000;
    if (hw_zero(k, a)) return 16'h0000;
`ifdef GP_REGFILE_BYPASS_EN
    if (wr_enable && wr_addr == a) return wr_data;
`endif
    return m_reg[k][a];
  endfunction

  function automatic logic exp_rdy(int k);
    logic freed;
    freed = wr_enable && (wr_addr == rsv_addr);
    return rsv_valid && !(m_busy[k][rsv_addr] && !freed);
  endfunction

  always @(posedge clk or posedge reset) begin : model
    logic [3:0] b;
    logic       r;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int a = 0; a < 4; a++) m_reg[k][a] <= 16'h0000;
        m_busy[k] <= 4'b0000;
        m_done[k] <= 1'b0;
        m_err[k]  <= 1'b0;
      end else begin
        b = m_busy[k];
        r = exp_rdy(k);
        if (wr_enable) begin
          if (!hw_zero(k, wr_addr)) begin
            if (!m_busy[k][wr_addr]) m_err[k] <= 1'b1;
            m_reg[k][wr_addr] <= wr_data;
          end
          b[wr_addr] = 1'b0;
        end
        if (r && !hw_zero(k, rsv_addr)) b[rsv_addr] = 1'b1;
        m_busy[k] <= b;
        m_done[k] <= wr_enable;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, sampled away from the rising edge.
  always @(negedge clk) begin
    chk("u0.rd_a", 64'(rda0), 64'(exp_rd(0, rd_a_addr)));
    chk("u0.rd_b", 64'(rdb0), 64'(exp_rd(0, rd_b_addr)));
    chk("u0.busy", 64'(busy0), 64'(m_busy[0]));
    chk("u0.rsv_ready", 64'(rdy0), 64'(exp_rdy(0)));
    chk("u0.wr_done", 64'(done0), 64'(m_done[0]));
    chk("u0.wr_err", 64'(err0), 64'(m_err[0]));
    chk("u1.rd_a", 64'(rda1), 64'(exp_rd(1, rd_a_addr)));
    chk("u1.rd_b", 64'(rdb1), 64'(exp_rd(1, rd_b_addr)));
    chk("u1.busy", 64'(busy1), 64'(m_busy[1]));
    chk("u1.rsv_ready", 64'(rdy1), 64'(exp_rdy(1)));
    chk("u1.wr_done", 64'(done1), 64'(m_done[1]));
    chk("u1.wr_err", 64'(err1), 64'(m_err[1]));
  end

  // ---------------- stimulus ----------------
  task automatic idle(logic [1:0] ra, logic [1:0] rb);
    rsv_valid = 1'b0; wr_enable = 1'b0; rd_a_addr = ra; rd_b_addr = rb;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset.busy", 64'(busy0), 64'h0);
    chk("reset.wr_done", 64'(done0), 64'h0);
    chk("reset.wr_err", 64'(err0), 64'h0);
    chk("reset.rd_a", 64'(rda0), 64'h0);
    next_cycle();
    reset = 1'b0;

    // Reserve register 1, retry, then write it.
    rsv_valid = 1'b1; rsv_addr = 2'd1;
    @(negedge clk);
    chk("rsv1.ready", 64'(rdy0), 64'h1);
    next_cycle();
    @(negedge clk);
    chk("rsv1.busy", 64'(busy0), 64'b0010);
    chk("rsv1.retry_ready", 64'(rdy0), 64'h0);
    next_cycle();
    rsv_valid = 1'b0; wr_enable = 1'b1; wr_addr = 2'd1; wr_data = 16'h1234;
    next_cycle();
    idle(2'd1, 2'd1);
    @(negedge clk);
    chk("wr1.busy", 64'(busy0), 64'h0);
    chk("wr1.wr_err", 64'(err0), 64'h0);
    chk("wr1.rd_a", 64'(rda0), 64'h1234);
    chk("wr1.wr_done", 64'(done0), 64'h1);
    next_cycle();

    // Reserve 3, then write and re-reserve 3 in the same cycle.
    rsv_valid = 1'b1; rsv_addr = 2'd3;
    next_cycle();
    wr_enable = 1'b1; wr_addr = 2'd3; wr_data = 16'h00AA;
    @(negedge clk);
    chk("tie3.ready", 64'(rdy0), 64'h1);
    next_cycle();
    idle(2'd3, 2'd3);
    @(negedge clk);
    chk("tie3.busy", 64'(busy0), 64'b1000);
    chk("tie3.rd_a", 64'(rda0), 64'h00AA);
    chk("tie3.wr_err", 64'(err0), 64'h0);
    next_cycle();

    // Same-cycle read of register 0 while it is written.
    wr_enable = 1'b1; wr_addr = 2'd0; wr_data = 16'h5A5A;
    rd_a_addr = 2'd0; rd_b_addr = 2'd0;
    @(negedge clk);
`ifdef GP_REGFILE_BYPASS_EN
    chk("byp0.rd_a", 64'(rda0), 64'h5A5A);
    chk("byp0.rd_b", 64'(rdb0), 64'h5A5A);
`else
    chk("byp0.rd_a", 64'(rda0), 64'h0000);
    chk("byp0.rd_b", 64'(rdb0), 64'h0000);
`endif
    chk("byp0.hw_rd_a", 64'(rda1), 64'h0000);
    next_cycle();
    idle(2'd0, 2'd0);
    @(negedge clk);
    chk("byp0.after", 64'(rda0), 64'h5A5A);
    chk("byp0.wr_err", 64'(err0), 64'h1);
    next_cycle();

    // Hardwired register 0 on u1.
    wr_enable = 1'b1; wr_addr = 2'd0; wr_data = 16'hFFFF;
    next_cycle();
    idle(2'd0, 2'd0);
    @(negedge clk);
    chk("hw0.rd_a", 64'(rda1), 64'h0000);
    chk("hw0.wr_done", 64'(done1), 64'h1);
    chk("hw0.wr_err", 64'(err1), 64'h0);
    chk("hw0.busy0", 64'(busy1[0]), 64'h0);
    next_cycle();

    // Reset pulse, with a write presented so it lands on the first edge after.
    reset = 1'b1;
    wr_enable = 1'b1; wr_addr = 2'd2; wr_data = 16'hBEEF;
    #2 reset = 1'b0;
    next_cycle();
    idle(2'd2, 2'd2);
    @(negedge clk);
    chk("beef.rd_a", 64'(rda0), 64'hBEEF);
    chk("beef.wr_done", 64'(done0), 64'h1);
    chk("beef.wr_err", 64'(err0), 64'h1);
    next_cycle();
    @(negedge clk);
    chk("beef.done_drop", 64'(done0), 64'h0);
    next_cycle();

    // Fill every register, then reset mid-cycle with a write pending.
    for (int a = 0; a < 4; a++) begin
      wr_enable = 1'b1; wr_addr = 2'(a); wr_data = 16'(16'h1111 * (a + 1));
      rsv_valid = 1'b1; rsv_addr = 2'(a);
      next_cycle();
    end
    wr_enable = 1'b1; wr_addr = 2'd1; wr_data = 16'hDEAD;
    rsv_valid = 1'b1; rsv_addr = 2'd2;
    rd_a_addr = 2'd1; rd_b_addr = 2'd2;
    #2 reset = 1'b1;
    #1;
    chk("rst.rd_a", 64'(rda0), 64'h0);
    chk("rst.rd_b", 64'(rdb0), 64'h0);
    chk("rst.busy", 64'(busy0), 64'h0);
    chk("rst.wr_err", 64'(err0), 64'h0);
    next_cycle();
    reset = 1'b0;
    idle(2'd1, 2'd2);
    @(negedge clk);
    chk("rst.discard_wr", 64'(rda0), 64'h0);
    chk("rst.discard_rsv", 64'(busy0), 64'h0);
    next_cycle();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      reset     = ($urandom_range(0, 99) < 2);
      rsv_valid = $urandom_range(0, 1) == 1;
      rsv_addr  = 2'($urandom_range(0, 3));
      wr_enable = $urandom_range(0, 2) != 0;
      wr_addr   = 2'($urandom_range(0, 3));
      wr_data   = 16'($urandom);
      rd_a_addr = 2'($urandom_range(0, 3));
      rd_b_addr = ($urandom_range(0, 3) == 0) ? rd_a_addr : 2'($urandom_range(0, 3));
      next_cycle();
    end
    reset = 1'b0;
    idle(2'd0, 2'd0);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/gp_regfile.md
GP_REGFILE -- requirements
Module: gp_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register data width in bits (4..64).
REQ-002 SHALL have parameter NUM_REGS, default 4, register count (power of two, 2..16).
REQ-003 SHALL have parameter ADDR_W, default $clog2(NUM_REGS), register index width.
REQ-004 SHALL have parameter HARDWIRE_R0, default 0, where 1 makes register 0 read as zero and ignore writes.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 rsv_valid  input  1  request to mark register rsv_addr busy.
REQ-008 rsv_addr  input  ADDR_W  register to reserve.
REQ-009 rsv_ready  output  1  reservation accepted this cycle (combinational).
REQ-010 wr_enable  input  1  write request.
REQ-011 wr_addr  input  ADDR_W  write destination.
REQ-012 wr_data  input  DATA_W  write data.
REQ-013 wr_done  output  1  registered one-cycle pulse confirming a commit.
REQ-014 wr_err  output  1  sticky flag: write to a non-busy register occurred.
REQ-015 rd_a_addr / rd_b_addr  input  ADDR_W each  read port indices.
REQ-016 rd_a_data / rd_b_data  output  DATA_W each  combinational read data.
REQ-017 busy  output  NUM_REGS  per-register scoreboard bits.

Function
REQ-018 Write SHALL commit wr_data to wr_addr on the rising edge when wr_enable=1; one write per cycle.
REQ-019 wr_done SHALL be 1 in the cycle after a commit, else 0; back-to-back writes SHALL hold it high continuously.
REQ-020 Reads SHALL be asynchronous, both ports independent; same address on both ports SHALL return identical data.
REQ-021 rsv_ready SHALL be rsv_valid AND NOT busy[rsv_addr], with busy[rsv_addr] overridden to 0 when a write to rsv_addr occurs in the same cycle.
REQ-022 Accepted reservation SHALL set busy[rsv_addr] on the next edge; a committed write SHALL clear busy[wr_addr].
REQ-023 Simultaneous write and accepted reservation to the same register SHALL leave busy=1 (reserve wins) with the data committed.
REQ-024 Write to a register with busy=0 SHALL still commit and SHALL set wr_err, which stays 1 until reset.
REQ-025 HARDWIRE_R0=1: register 0 reads 0, writes to it pulse wr_done with no data change, busy[0] always 0, rsv_ready=rsv_valid for address 0, wr_err unaffected by address 0.
REQ-026 Addresses SHALL use ADDR_W bits only; no out-of-range state exists.

Reset
REQ-027 reset SHALL asynchronously clear all registers, busy, wr_done and wr_err to 0.
REQ-028 Reset asserted mid-sequence SHALL discard any same-edge write or reservation; reads return 0 during reset.
REQ-029 First write or reservation SHALL be honoured on the first rising edge after reset deasserts.

Configuration
REQ-030 Macro GP_REGFILE_BYPASS_EN defined: a read port whose address equals wr_addr while wr_enable=1 SHALL return wr_data in the same cycle (write-through), except register 0 when HARDWIRE_R0=1.
REQ-031 Macro undefined: reads SHALL return the stored value; a same-cycle write becomes visible only after the edge.

Verification
REQ-032 Reset, then wr_enable, wr_addr=2, wr_data=16'hBEEF with busy[2]=0 -> next cycle rd_a_addr=2 reads 16'hBEEF, wr_done=1 one cycle, wr_err=1.
REQ-033 rsv_valid, rsv_addr=1 -> rsv_ready=1, busy=4'b0010; repeat -> rsv_ready=0; write 16'h1234 to 1 -> busy=4'b0000, wr_err stays 0.
REQ-034 Same cycle: write 16'h00AA to 3 (busy) and reserve 3 -> busy[3]=1, reg3=16'h00AA, rsv_ready=1.
REQ-035 BYPASS_EN: write 16'h5A5A to 0, rd_a_addr=rd_b_addr=0 same cycle -> both read 16'h5A5A; without macro both read the old value 16'h0000.
REQ-036 HARDWIRE_R0=1: write 16'hFFFF to 0 -> rd_a_data=16'h0000, wr_done pulses, wr_err=0.
REQ-037 Reset pulse between two clock edges after filling all registers -> all reads 0, busy=0, wr_err=0 immediately.
